// File: rtl/spi_cmd_initiator.sv
// SPI mode-0 master that shifts 16-bit {rw, addr, data} frames out MSB first on nCS/SCLK/COPI.
// Optional response capture on CIPO is enabled with `define SPI_CMD_CIPO_EN.
module spi_cmd_initiator #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  input  logic       cipo,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  localparam logic [5:0] EDGES  = 6'(2 * FRAME_BITS);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  edge_q, edge_d;
  logic [15:0] sh_q, sh_d;
  logic        ncs_q, ncs_d, sclk_q, sclk_d, copi_q, copi_d;
  logic        busy_q, busy_d, done_q, done_d, ready_q, ready_d;
  logic        tick, rise_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sh_d    = sh_q;
    ncs_d   = ncs_q;
    sclk_d  = sclk_q;
    copi_d  = copi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    rise_d  = 1'b0;
    tick    = (cnt_q == 8'd0);
    if (state_q != S_IDLE && !tick) cnt_d = cnt_q - 8'd1;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = S_SETUP;
          sh_d    = {cmd_rw, cmd_addr, cmd_data};
          copi_d  = cmd_rw;
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          cnt_d   = DIV_M1;
          edge_d  = 6'd0;
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          rise_d  = 1'b1;
          edge_d  = 6'd1;
          cnt_d   = DIV_M1;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          cnt_d = DIV_M1;
          if (edge_q == EDGES) begin
            state_d = S_HOLD;
          end else begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 6'd1;
            // The final falling edge leaves bit 0 on copi through HOLD.
            if (sclk_q && (edge_q + 6'd1) != EDGES) begin
              sh_d   = sh_q << 1;
              copi_d = sh_q[14];
            end
            rise_d = ~sclk_q;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_GAP;
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          copi_d  = 1'b0;
          cnt_d   = DIV_M1;
        end
      end
      S_GAP: begin
        if (tick) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 6'd0;
      ncs_q   <= 1'b1;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      ncs_q   <= ncs_d;
      sclk_q  <= sclk_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
    sh_q <= sh_d;
  end

`ifdef SPI_CMD_CIPO_EN
  logic [7:0] rx_q, rx_d, rd_q, rd_d;

  always_comb begin
    rx_d = rx_q;
    rd_d = rd_q;
    if (rise_d) rx_d = {rx_q[6:0], cipo};
    if (done_d) rd_d = rx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= 8'd0;
    else        rd_q <= rd_d;
    rx_q <= rx_d;
  end

  assign rd_data = rd_q;
`else
  logic unused_cipo;
  assign unused_cipo = cipo ^ rise_d;
  assign rd_data     = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (FRAME_BITS == 16);
      assert (!(ncs_q && sclk_q));
    end
  end

  assign cmd_ready = ready_q;
  assign ncs       = ncs_q;
  assign sclk      = sclk_q;
  assign copi      = copi_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_spi_cmd_initiator.sv
// Bench for spi_cmd_initiator: cycle-indexed waveform model, SPI peripheral decoder with
// register file, back-to-back, busy-noise, mid-frame reset and CIPO capture scenarios.
module tb_spi_cmd_initiator;
  localparam int D  = 4;
  localparam int FP = 35 * D + 1;

  logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_rw = 1'b0, cipo = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, ncs, sclk, copi, busy, done;
  logic [7:0] rd_data;

  int checks = 0, errors = 0;

  spi_cmd_initiator #(.CLK_DIV(D), .FRAME_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .ncs(ncs), .sclk(sclk), .copi(copi), .cipo(cipo),
    .busy(busy), .done(done), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peripheral-side model
  logic [7:0]  regs [128];
  logic [15:0] sr = '0, last_frame = '0, resp = '0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
  int          nb = 0, rc = 0, total_rises = 0, frame_cnt = 0, done_cnt = 0;
  time         acc_t [$];
  logic [7:0]  exp_rd = 8'h00;

  always @(posedge clk)
    if (rst_n && cmd_valid && cmd_ready) acc_t.push_back($time);

  always @(negedge clk) begin
    if (prev_ncs && !ncs) begin nb = 0; rc = 0; end
    if (!ncs && !prev_sclk && sclk) begin
      sr = {sr[14:0], copi};
      nb++; rc++; total_rises++;
    end
    check("sclk high with ncs high", 32'(ncs & sclk), 32'd0);
    if (!prev_ncs && ncs && done) check("ncs rise with sclk low", 32'(prev_sclk | sclk), 32'd0);
    if (!prev_ncs && ncs && nb == 16) begin
      last_frame = sr;
      frame_cnt++;
      if (sr[15]) regs[sr[14:8]] = sr[7:0];
    end
    if (done) done_cnt++;
    cipo = (!ncs && rc < 16) ? resp[15 - rc] : 1'b0;
    prev_ncs  = ncs;
    prev_sclk = sclk;
  end

  // Expected {ncs, sclk, copi, busy, done, cmd_ready}, j clock edges after the accepting edge.
  function automatic logic [5:0] exp_sig(input int j, input logic [15:0] f);
    logic ncs_e, sclk_e, copi_e;
    int   bi;
    ncs_e  = (j >= 34 * D);
    sclk_e = (j >= D) && (j < 33 * D) && ((((j - D) / D) % 2) == 0);
    bi     = j / (2 * D);
    if (bi > 15) bi = 15;
    copi_e = (j < 34 * D) ? f[15 - bi] : 1'b0;
    return {ncs_e, sclk_e, copi_e, (j < 35 * D), (j == 34 * D), (j >= 35 * D)};
  endfunction

  function automatic logic [7:0] cap_val(input logic [15:0] r);
`ifdef SPI_CMD_CIPO_EN
    return r[7:0];
`else
    return 8'h00 & r[7:0];
`endif
  endfunction

  task automatic run_frame(input logic [15:0] f, input bit noise, input string tag);
    int         fc0;
    logic [7:0] new_rd;
    @(negedge clk);
    check({tag, " ready before"}, 32'(cmd_ready), 32'd1);
    {cmd_rw, cmd_addr, cmd_data} = f;
    cmd_valid = 1'b1;
    fc0    = frame_cnt;
    new_rd = cap_val(resp);
    @(posedge clk);
    for (int j = 0; j <= 35 * D; j++) begin
      @(negedge clk);
      if (noise && j < 30 * D) begin
        cmd_valid = 1'($urandom_range(0, 1));
        {cmd_rw, cmd_addr, cmd_data} = 16'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      check({tag, " pins"}, 32'({ncs, sclk, copi, busy, done, cmd_ready}), 32'(exp_sig(j, f)));
      check({tag, " rd_data"}, 32'(rd_data), 32'((j >= 34 * D) ? new_rd : exp_rd));
    end
    exp_rd = new_rd;
    #1;
    check({tag, " decoded frame"}, 32'(last_frame), 32'(f));
    check({tag, " frame count"}, 32'(frame_cnt), 32'(fc0 + 1));
  endtask

  logic [7:0] b2b [5] = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'h80};

  initial begin
    int r0, dn0, fc0, base, to;
    logic [15:0] f;

    // 1: reset
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset pins", 32'({ncs, sclk, copi, busy, done, cmd_ready}), 32'(6'b100001));
    check("reset rd_data", 32'(rd_data), 32'd0);

    // 2: single write 0x80F0
    resp = 16'($urandom);
    r0 = total_rises;
    run_frame(16'h80F0, 1'b0, "t2");
    check("t2 sclk rises", 32'(total_rises - r0), 32'd16);
    check("t2 reg0", 32'(regs[0]), 32'hF0);

    // random frames
    for (int i = 0; i < 4; i++) begin
      resp = 16'($urandom);
      f    = 16'($urandom);
      run_frame(f, 1'b0, "rnd");
    end

    // 3: five back-to-back writes with cmd_valid held
    @(negedge clk);
    base = acc_t.size();
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {cmd_rw, cmd_addr, cmd_data} = {1'b1, 7'(i), b2b[i]};
      to = 0;
      while (acc_t.size() < base + i + 1 && to < 2 * FP) begin @(negedge clk); to++; end
      check("t3 accept", 32'(acc_t.size() - base), 32'(i + 1));
    end
    cmd_valid = 1'b0;
    to = 0;
    while (!cmd_ready && to < 2 * FP) begin @(negedge clk); to++; end
    #1;
    check("t3 idle", 32'(cmd_ready), 32'd1);
    for (int i = 1; i < 5; i++)
      if (acc_t.size() > base + i)
        check("t3 accept spacing", 32'((acc_t[base + i] - acc_t[base + i - 1]) / 10), 32'(FP));
    for (int i = 0; i < 5; i++) check("t3 regfile", 32'(regs[i]), 32'(b2b[i]));
    exp_rd = cap_val(resp);

    // 4: cmd_valid/cmd_data noise while busy
    resp = 16'($urandom);
    run_frame(16'($urandom), 1'b1, "t4");

    // 5: reset at the 9th sclk rise
    @(negedge clk);
    r0 = total_rises; dn0 = done_cnt; fc0 = frame_cnt;
    resp = 16'($urandom);
    {cmd_rw, cmd_addr, cmd_data} = 16'($urandom);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    to = 0;
    while (total_rises < r0 + 9 && to < 400) begin @(negedge clk); #1; to++; end
    check("t5 ninth rise", 32'(total_rises - r0), 32'd9);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5 reset pins", 32'({ncs, sclk, copi, busy, done, cmd_ready}), 32'(6'b100001));
    check("t5 reset rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("t5 no done", 32'(done_cnt), 32'(dn0));
    check("t5 frame dropped", 32'(frame_cnt), 32'(fc0));
    exp_rd = 8'h00;
    resp = 16'($urandom);
    run_frame(16'($urandom), 1'b0, "t5 next");

    // 6: response capture
    resp = {8'($urandom), 8'h3C};
    run_frame(16'($urandom), 1'b0, "t6");
`ifdef SPI_CMD_CIPO_EN
    check("t6 rd_data", 32'(rd_data), 32'h3C);
`else
    check("t6 rd_data", 32'(rd_data), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
